// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: widths, requester ids
// and the write-request payload carried from writeback to the write port.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    // Requester ids as they appear on grantId and in the round-robin pointer.
    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] adrx;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

    // The requester that should win the next tie after `id` was granted.
    function automatic logic otherReq(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback handshakes plus the register-file write port and
// debug counter. The master side belongs to the writeback stages and the
// register file; the slave side is the arbiter.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned CNT_W  = 16
);

    // ALU writeback requester
    logic              req0Valid;
    logic              req0Ready;
    logic [ADDR_W-1:0] req0Adrx;
    logic [DATA_W-1:0] req0Data;

    // Load writeback requester
    logic              req1Valid;
    logic              req1Ready;
    logic [ADDR_W-1:0] req1Adrx;
    logic [DATA_W-1:0] req1Data;

    // Registered register-file write port
    logic              writeEn;
    logic [ADDR_W-1:0] writeAdrx;
    logic [DATA_W-1:0] writeData;
    logic              grantId;

    logic [CNT_W-1:0]  contentionCnt;

    modport master (
        output req0Valid, req0Adrx, req0Data,
        input  req0Ready,
        output req1Valid, req1Adrx, req1Data,
        input  req1Ready,
        input  writeEn, writeAdrx, writeData, grantId,
        input  contentionCnt
    );

    modport slave (
        input  req0Valid, req0Adrx, req0Data,
        output req0Ready,
        input  req1Valid, req1Adrx, req1Data,
        output req1Ready,
        output writeEn, writeAdrx, writeData, grantId,
        output contentionCnt
    );

endinterface

// File: rtl/regfile_write_arbiter_wr_hold_buf.sv
// One-entry holding buffer in front of the write arbiter. It accepts a request
// whenever it is empty or is being drained this cycle, so a lone requester can
// stream one write per cycle without bubbles.
module wr_hold_buf #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [ADDR_W-1:0] adrx,
    input  logic [DATA_W-1:0] data,
    input  logic              grant,
    output logic              full,
    output logic              ready,
    output logic [ADDR_W-1:0] heldAdrx,
    output logic [DATA_W-1:0] heldData
);

    logic              fullQ;
    logic [ADDR_W-1:0] adrxQ;
    logic [DATA_W-1:0] dataQ;
    logic              load;

    // Ready depends only on local state and the grant, never on valid.
    always_comb begin
        ready = !fullQ || grant;
        load  = valid && ready;
    end

    // Load on handshake (refill wins over drain), otherwise empty on grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fullQ <= 1'b0;
            adrxQ <= '0;
            dataQ <= '0;
        end else if (load) begin
            fullQ <= 1'b1;
            adrxQ <= adrx;
            dataQ <= data;
        end else if (grant) begin
            fullQ <= 1'b0;
        end
    end

    assign full     = fullQ;
    assign heldAdrx = adrxQ;
    assign heldData = dataQ;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between ALU writeback (0) and
// load writeback (1). Each requester lands in a one-entry buffer; a round-robin
// arbiter drains the buffers into registered write-port outputs, and a
// saturating counter tracks cycles where both buffers were waiting.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              full0;
    logic              full1;
    logic              grant0;
    logic              grant1;
    logic              bothFull;
    logic [ADDR_W-1:0] held0Adrx;
    logic [DATA_W-1:0] held0Data;
    logic [ADDR_W-1:0] held1Adrx;
    logic [DATA_W-1:0] held1Data;

    logic              rrPtr;
    logic              writeEnQ;
    logic [ADDR_W-1:0] writeAdrxQ;
    logic [DATA_W-1:0] writeDataQ;
    logic              grantIdQ;
    logic [CNT_W-1:0]  contentionCntQ;

    wr_hold_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) aluBuf (
        .clk      (clk),
        .reset    (reset),
        .valid    (bus.req0Valid),
        .adrx     (bus.req0Adrx),
        .data     (bus.req0Data),
        .grant    (grant0),
        .full     (full0),
        .ready    (bus.req0Ready),
        .heldAdrx (held0Adrx),
        .heldData (held0Data)
    );

    wr_hold_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) loadBuf (
        .clk      (clk),
        .reset    (reset),
        .valid    (bus.req1Valid),
        .adrx     (bus.req1Adrx),
        .data     (bus.req1Data),
        .grant    (grant1),
        .full     (full1),
        .ready    (bus.req1Ready),
        .heldAdrx (held1Adrx),
        .heldData (held1Data)
    );

    // Grant a lone full buffer outright; on a tie the round-robin pointer decides.
    always_comb begin
        bothFull = full0 && full1;
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (bothFull) begin
            if (rrPtr == REQ_ALU) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = full0;
            grant1 = full1;
        end
    end

    // Register the granted entry onto the write port; address/data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeEnQ   <= 1'b0;
            writeAdrxQ <= '0;
            writeDataQ <= '0;
            grantIdQ   <= REQ_ALU;
            rrPtr      <= REQ_ALU;
        end else if (grant0) begin
            writeEnQ   <= 1'b1;
            writeAdrxQ <= held0Adrx;
            writeDataQ <= held0Data;
            grantIdQ   <= REQ_ALU;
            rrPtr      <= otherReq(REQ_ALU);
        end else if (grant1) begin
            writeEnQ   <= 1'b1;
            writeAdrxQ <= held1Adrx;
            writeDataQ <= held1Data;
            grantIdQ   <= REQ_LOAD;
            rrPtr      <= otherReq(REQ_LOAD);
        end else begin
            writeEnQ   <= 1'b0;
        end
    end

    // Count cycles with both buffers waiting, pinned at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contentionCntQ <= '0;
        end else if (bothFull && (contentionCntQ != CNT_MAX)) begin
            contentionCntQ <= contentionCntQ + 1'b1;
        end
    end

    assign bus.writeEn       = writeEnQ;
    assign bus.writeAdrx     = writeAdrxQ;
    assign bus.writeData     = writeDataQ;
    assign bus.grantId       = grantIdQ;
    assign bus.contentionCnt = contentionCntQ;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter. Requests come from
// per-requester source queues and are compared every cycle against a
// transaction-level model of buffers, round-robin tie-break and counter.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(
        .DATA_W(REG_DATA_W),
        .ADDR_W(REG_ADDR_W),
        .CNT_W (CNT_W)
    ) bus ();

    regfile_write_arbiter #(
        .DATA_W(REG_DATA_W),
        .ADDR_W(REG_ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checkCnt = 0;
    int passCnt  = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Register file as seen through the DUT's write port.
    logic [REG_DATA_W-1:0] rf [32];
    always @(posedge clk) if (bus.writeEn) rf[bus.writeAdrx] <= bus.writeData;

    // Reference model state
    bit                    mFull [2];
    wr_req_t               mEnt  [2];
    int                    mRr;
    bit                    mEn;
    wr_req_t               mOut;
    int                    mGid;
    int                    mCnt;
    logic [REG_DATA_W-1:0] mRegs    [32];
    bit                    mWritten [32];

    wr_req_t src0 [$];
    wr_req_t src1 [$];

    function automatic void modelReset();
        mFull[0] = 0; mFull[1] = 0;
        mEnt[0]  = '0; mEnt[1] = '0;
        mRr = 0; mEn = 0; mOut = '0; mGid = 0; mCnt = 0;
    endfunction

    function automatic int modelSel();
        if (mFull[0] && mFull[1]) return mRr;
        if (mFull[0]) return 0;
        if (mFull[1]) return 1;
        return -1;
    endfunction

    function automatic wr_req_t mkReq(input int a, input logic [31:0] d);
        wr_req_t r;
        r.adrx = a[REG_ADDR_W-1:0];
        r.data = d;
        return r;
    endfunction

    // One clock: present the heads of the source queues, check, advance model.
    task automatic stepCycle();
        bit      v   [2];
        bit      rdy [2];
        wr_req_t r   [2];
        int      sel;
        v[0] = src0.size() > 0;
        v[1] = src1.size() > 0;
        r[0] = v[0] ? src0[0] : '0;
        r[1] = v[1] ? src1[0] : '0;
        bus.req0Valid = v[0]; bus.req0Adrx = r[0].adrx; bus.req0Data = r[0].data;
        bus.req1Valid = v[1]; bus.req1Adrx = r[1].adrx; bus.req1Data = r[1].data;
        #1;
        sel    = modelSel();
        rdy[0] = !mFull[0] || sel == 0;
        rdy[1] = !mFull[1] || sel == 1;
        checkVal("req0Ready", bus.req0Ready, rdy[0]);
        checkVal("req1Ready", bus.req1Ready, rdy[1]);
        checkVal("writeEn", bus.writeEn, mEn);
        checkVal("writeAdrx", bus.writeAdrx, mOut.adrx);
        checkVal("writeData", bus.writeData, mOut.data);
        if (mEn) checkVal("grantId", bus.grantId, mGid);
        checkVal("contentionCnt", bus.contentionCnt, mCnt);
        if (mFull[0] && mFull[1] && mCnt < CNT_MAX) mCnt++;
        if (sel >= 0) begin
            mOut = mEnt[sel];
            mEn  = 1;
            mGid = sel;
            mRr  = 1 - sel;
            mFull[sel] = 0;
            mRegs[mOut.adrx]    = mOut.data;
            mWritten[mOut.adrx] = 1;
        end else begin
            mEn = 0;
        end
        if (v[0] && rdy[0]) begin mEnt[0] = r[0]; mFull[0] = 1; void'(src0.pop_front()); end
        if (v[1] && rdy[1]) begin mEnt[1] = r[1]; mFull[1] = 1; void'(src1.pop_front()); end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((src0.size() > 0 || src1.size() > 0 || mFull[0] || mFull[1] || mEn) && n < 300) begin
            stepCycle();
            n++;
        end
        if (n >= 300) checkVal("drainTimeout", 1, 0);
        stepCycle();
        stepCycle();
    endtask

    initial begin
        reset = 1'b1;
        bus.req0Valid = 0; bus.req0Adrx = '0; bus.req0Data = '0;
        bus.req1Valid = 0; bus.req1Adrx = '0; bus.req1Data = '0;
        modelReset();
        for (int i = 0; i < 32; i++) begin mRegs[i] = '0; mWritten[i] = 0; end
        repeat (2) @(posedge clk);
        #1;
        checkVal("rstWriteEn", bus.writeEn, 0);
        checkVal("rstReady0", bus.req0Ready, 1);
        checkVal("rstReady1", bus.req1Ready, 1);
        checkVal("rstCnt", bus.contentionCnt, 0);
        checkVal("rstAdrx", bus.writeAdrx, 0);
        checkVal("rstData", bus.writeData, 0);
        reset = 1'b0;
        stepCycle();

        // Single write from the ALU requester
        src0.push_back(mkReq(5, 32'hDEADBEEF));
        drain();
        checkVal("reg5", rf[5], 32'hDEADBEEF);

        // Load requester streaming addresses 1..8
        for (int i = 1; i <= 8; i++) src1.push_back(mkReq(i, 32'h1000 + i));
        drain();

        // Both requesters every cycle: alternating grants, counter rising
        for (int i = 0; i < 6; i++) begin
            src0.push_back(mkReq(10 + i, $urandom));
            src1.push_back(mkReq(20 + i, $urandom));
        end
        drain();

        // Same-address collision with the pointer at the ALU requester
        if (mRr != 0) begin
            src1.push_back(mkReq(30, $urandom));
            drain();
        end
        checkVal("rrBeforeCollision", mRr, 0);
        src0.push_back(mkReq(7, 32'h11));
        src1.push_back(mkReq(7, 32'h22));
        drain();
        checkVal("reg7", rf[7], 32'h22);

        // Sustained contention saturates the counter
        for (int i = 0; i < 20; i++) begin
            src0.push_back(mkReq($urandom_range(0, 31), $urandom));
            src1.push_back(mkReq($urandom_range(0, 31), $urandom));
        end
        drain();
        checkVal("cntSat", bus.contentionCnt, 15);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if (src0.size() < 2 && $urandom_range(0, 3) != 0)
                src0.push_back(mkReq($urandom_range(0, 31), $urandom));
            if (src1.size() < 2 && $urandom_range(0, 2) == 0)
                src1.push_back(mkReq($urandom_range(0, 31), $urandom));
            stepCycle();
        end
        drain();

        // Reset while a buffer holds a write: entry discarded, no write pulse
        src0.push_back(mkReq(9, 32'hBADBAD00));
        stepCycle();
        reset = 1'b1;
        bus.req0Valid = 0;
        bus.req1Valid = 0;
        #1;
        checkVal("midRstWriteEn", bus.writeEn, 0);
        checkVal("midRstReady0", bus.req0Ready, 1);
        checkVal("midRstCnt", bus.contentionCnt, 0);
        modelReset();
        @(posedge clk);
        #1;
        checkVal("midRstHoldEn", bus.writeEn, 0);
        reset = 1'b0;
        repeat (3) stepCycle();

        for (int a = 0; a < 32; a++)
            if (mWritten[a]) checkVal($sformatf("rf[%0d]", a), rf[a], mRegs[a]);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: requester 0 is ALU writeback and requester 1 is memory-load writeback. Each requester has a valid/ready handshake into its own one-entry holding buffer. A round-robin arbiter drains the buffers into a registered write port (`writeAdrx`/`writeData`/`writeEn`) that drives the 32×32 register file directly. A saturating counter records write-port contention cycles for performance debug.

## Interface
- `DATA_W`, 32, write data width; matches the register file word.
- `ADDR_W`, 5, register address width (32 registers).
- `CNT_W`, 16, width of the contention counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req0Valid`  in  1  ALU write request valid.
- `req0Ready`  out  1  ALU holding buffer can accept.
- `req0Adrx`  in  ADDR_W  ALU destination register.
- `req0Data`  in  DATA_W  ALU result.
- `req1Valid`, `req1Ready`, `req1Adrx`, `req1Data`  same as req0, for the load requester.
- `writeEn`  out  1  register file write enable (registered).
- `writeAdrx`  out  ADDR_W  register file write address (registered).
- `writeData`  out  DATA_W  register file write data (registered).
- `grantId`  out  1  requester whose write is currently on the port; valid when `writeEn`=1.
- `contentionCnt`  out  CNT_W  saturating count of cycles in which both buffers were full.

## Operation
- Per requester: a one-entry buffer holding `full`, `adrx` and `data`.
  - `reqNReady` = !full || granted this cycle (combinational).
  - A transfer happens when `reqNValid` && `reqNReady`; it loads the buffer at the clock edge.
- Arbitration is combinational over the buffer `full` flags.
  - Only one buffer full: that buffer is granted.
  - Both full: the buffer named by round-robin pointer `rrPtr` is granted.
  - Neither full: no grant.
- On a grant:
  - The buffer contents move into the output registers, with `writeEn`=1 and `grantId` set to the requester.
  - The buffer empties unless refilled in the same cycle.
  - `rrPtr` is set to the other requester.
- No grant: `writeEn` goes to 0 at the next edge. `writeAdrx` and `writeData` hold their last values.
- `rrPtr` changes only on a grant. Its reset value is 0, so requester 0 wins the first tie.
- `contentionCnt` increments on every edge where both buffers are full. It saturates at 2^CNT_W−1 and never wraps.
- No filtering of address 0: the block passes through every write it accepts.
- Both buffers may hold the same address. Both writes are issued in grant order, so the later-granted value is final in the register file.

## Timing
- Reset values:
  - Outputs: `writeEn`=0, `writeAdrx`=0, `writeData`=0, `grantId`=0, `contentionCnt`=0, `req0Ready`=`req1Ready`=1.
  - Internal state: buffers empty, `rrPtr`=0.
- Latency for an uncontended request:
  - Accepted at edge E0.
  - Granted in the cycle after E0; `writeEn` asserts after edge E1.
  - The register file captures the write at E2.
- Throughput:
  - One write per cycle in aggregate.
  - A lone requester sustains one request per cycle, because `ready` stays high while its buffer is being granted.
  - Under continuous contention, each requester gets one write every 2 cycles (strict alternation).
- Simultaneous refill: a buffer granted and refilled at the same edge holds the new entry and stays full. No bubble is inserted.
- `ready` depends on the grant, which depends only on the `full` flags and `rrPtr`. There is no combinational path from `valid` to `ready`.
- Reset asserted mid-operation:
  - Pending buffered writes are discarded.
  - `writeEn` drops asynchronously, so no partial write reaches the register file.
- Requesters must hold `valid`, `adrx` and `data` stable until the handshake completes.

## Structure
- Shared package `regfile_pkg`:
  - `REG_ADDR_W`=5 and `REG_DATA_W`=32.
  - Requester-id constants `REQ_ALU`=0 and `REQ_LOAD`=1.
  - The `wr_req_t` struct (`adrx`, `data`).
- Sub-module `wr_hold_buf`:
  - One-entry buffer with handshake: inputs `valid`, `adrx`, `data`, `grant`; outputs `full`, `ready`, held `adrx`/`data`.
  - Instantiated twice.
- The top level holds the arbiter, `rrPtr`, output registers and contention counter.

## Test plan
- Reset check: after reset, `writeEn`=0, both `ready`=1, `contentionCnt`=0. Assert `reset` one cycle while a buffer is full → the buffer clears and no `writeEn` pulse follows.
- Single write: `req0` writes `adrx`=5, `data`=0xDEADBEEF at E0 → `writeEn`=1, `writeAdrx`=5, `writeData`=0xDEADBEEF, `grantId`=0 in the cycle after E1. The register file reads 0xDEADBEEF at address 5 after E2.
- Streaming single requester: `req1` valid for 8 consecutive cycles with addresses 1..8 → `req1Ready` stays 1 throughout, and 8 back-to-back `writeEn` cycles occur in order.
- Tie and round-robin: both requesters valid every cycle for 6 cycles.
  - Grants alternate 0,1,0,1,…, starting with 0.
  - `contentionCnt` increments once per cycle in which both buffers are full.
  - Each `ready` toggles so that no request is lost.
- Same-address collision: `req0` writes (7, 0x11) and `req1` writes (7, 0x22) in the same cycle with `rrPtr`=0 → two writes, 0x11 then 0x22. Register 7 ends at 0x22.
- Counter saturation: with `CNT_W`=4, hold contention for 20 cycles → `contentionCnt` stops at 15.
